apb_master_fsm: RTL and testbench
=================================

# apb_master_fsm

APB-side transfer sequencer for the AHB-to-APB bridge. It accepts one latched AHB request at a time: valid, direction, address and write data. It then decodes the address into one of three peripheral selects and drives a standard two-phase APB transfer: SETUP, then ACCESS. Read data is returned to the AHB side with a one-cycle done strobe. The block sits between the bridge's AHB slave interface and the APB interface. The APB bus has no PREADY, so every ACCESS lasts exactly one cycle.

## Interface
- No parameters. The address map is fixed (see Operation).
- Hclk  input  1  bridge clock; all state changes on the rising edge.
- Hresetn  input  1  asynchronous, active-low reset.
- valid  input  1  AHB request pending (NONSEQ/SEQ, HSEL, in-map).
- hwrite_reg  input  1  1 = write, 0 = read; sampled with valid.
- haddr  input  32  request address; sampled with valid.
- hwdata  input  32  write data; sampled one cycle after acceptance (AHB data phase).
- prdata  input  32  APB read data; valid during a read ACCESS cycle.
- hready_out  output  1  1 = block can accept a request this cycle.
- hrdata  output  32  last completed read data (registered).
- rd_done  output  1  one-cycle pulse: hrdata updated this cycle.
- pwrite  output  1  APB PWRITE.
- penable  output  1  APB PENABLE.
- psel  output  3  APB PSEL, one-hot or zero.
- paddr  output  32  APB PADDR.
- pwdata  output  32  APB PWDATA.

## Operation
- A request is accepted on an edge where valid=1, hready_out=1 and haddr is in-map.
- On acceptance, haddr and hwrite_reg are latched.
- Address decode of the latched address:
  - 0x8000_0000–0x83FF_FFFF → psel=3'b001.
  - 0x8400_0000–0x87FF_FFFF → psel=3'b010.
  - 0x8800_0000–0x8BFF_FFFF → psel=3'b100.
- If valid=1 with an out-of-map address: no acceptance, no state change, psel stays 0, hready_out stays as it is.
- States:
  - IDLE: hready_out=1; all APB controls deasserted.
  - READ (setup): psel, paddr, pwrite=0, penable=0; hready_out=0.
  - RENABLE (access): penable=1; hready_out=1.
  - WWAIT: hready_out=0; APB idle; hwdata is captured at the edge ending this state.
  - WRITE (setup): psel, paddr, pwdata, pwrite=1, penable=0; hready_out=0.
  - WENABLE (access): penable=1; hready_out=1.
- Transitions:
  - IDLE → READ on an accepted read; IDLE → WWAIT on an accepted write.
  - READ → RENABLE; WWAIT → WRITE; WRITE → WENABLE (all unconditional).
  - From RENABLE or WENABLE: on an accepted read → READ; on an accepted write → WWAIT; otherwise → IDLE.
- Back-to-back transfers: penable drops for the new SETUP cycle. psel changes to the new decode; it stays asserted if the slave is the same.
- hrdata is loaded from prdata at the edge ending RENABLE. rd_done=1 for the following cycle only. hrdata then holds until the next read completes.
- Writes never modify hrdata or pulse rd_done.
- All outputs are registered. No combinational path exists from any input to any output.

## Timing
- Reset (Hresetn=0, any time, asynchronous):
  - state=IDLE, hready_out=1.
  - psel=0, penable=0, pwrite=0.
  - paddr=0, pwdata=0, hrdata=0, rd_done=0.
  - Any in-flight transfer is dropped; no partial ACCESS completes.
- Read accepted at edge k:
  - Cycle k+1: SETUP.
  - Cycle k+2: ACCESS, hready_out=1.
  - Cycle k+3: hrdata valid, rd_done=1.
- Write accepted at edge k:
  - Cycle k+1: WWAIT; upstream holds hwdata stable.
  - Cycle k+2: SETUP with pwdata.
  - Cycle k+3: ACCESS, hready_out=1.
  - Edge k+4: IDLE, or the next transfer begins.
- Throughput: 2 cycles per read and 3 cycles per write when requests are continuous.
- paddr, pwdata and pwrite are stable from SETUP through ACCESS. penable is never asserted without psel.

## Test plan
- Reset mid-write:
  - Stimulus: assert Hresetn=0 during WRITE, between clock edges.
  - Response: all outputs go to their reset values immediately; no ACCESS is seen; the next request after release is handled normally from IDLE.
- Single write:
  - Stimulus: valid with 0x8000_0010, write; hwdata=0xA5A5_0001 one cycle later.
  - Response: SETUP at k+2 with psel=001, paddr=0x8000_0010, pwdata=0xA5A5_0001, pwrite=1; penable=1 at k+3; IDLE at k+4.
- Single read from slave 2:
  - Stimulus: read of 0x8400_0020; prdata=0x0000_005C during ACCESS.
  - Response: psel=010 at k+1 and k+2; penable=1 at k+2; hrdata=0x0000_005C with rd_done=1 at k+3 only.
- Back-to-back write then read:
  - Stimulus: write 0x8800_0000 (data 0x1234_5678), then a read of 0x8800_0004 presented during WENABLE.
  - Response: penable sequence 0,1,0,1; no IDLE cycle between transfers; psel=100 held throughout.
- Out-of-map request:
  - Stimulus: valid with 0x9000_0000.
  - Response: hready_out stays 1, psel=000, state stays IDLE, rd_done stays 0.

Source files
------------

// File: rtl/apb_master_fsm.sv
// apb_master_fsm
// APB-side transfer sequencer for the AHB-to-APB bridge. Takes one latched
// AHB request at a time, decodes it to one of three peripheral selects and
// runs a two-phase APB transfer (SETUP then a single-cycle ACCESS). Every
// output is a flop; next values are computed from the next state so that no
// input reaches an output combinationally.

module apb_master_fsm (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic        valid,
    input  logic        hwrite_reg,
    input  logic [31:0] haddr,
    input  logic [31:0] hwdata,
    input  logic [31:0] prdata,
    output logic        hready_out,
    output logic [31:0] hrdata,
    output logic        rd_done,
    output logic        pwrite,
    output logic        penable,
    output logic [2:0]  psel,
    output logic [31:0] paddr,
    output logic [31:0] pwdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_RENABLE,
        S_WWAIT,
        S_WRITE,
        S_WENABLE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] addr_reg;
    logic [31:0] addr_next;

    logic        accept;
    logic        hready_next;
    logic [2:0]  psel_next;
    logic        penable_next;
    logic        pwrite_next;
    logic [31:0] paddr_next;
    logic [31:0] pwdata_next;

    // Top six address bits select one of three 64 MB windows at 0x8000_0000.
    function automatic logic [2:0] decode(input logic [5:0] top);
        case (top)
            6'b100000: decode = 3'b001;
            6'b100001: decode = 3'b010;
            6'b100010: decode = 3'b100;
            default:   decode = 3'b000;
        endcase
    endfunction

    // Acceptance needs a free sequencer and an address inside the map.
    assign accept = valid && hready_out && (decode(haddr[31:26]) != 3'b000);

    // Next state plus next values for every registered output. The transfer
    // direction is carried by the state path itself, so only the address is
    // held separately for use after the write data phase.
    always_comb begin
        state_next   = state;
        addr_next    = addr_reg;
        hready_next  = hready_out;
        psel_next    = psel;
        penable_next = penable;
        pwrite_next  = pwrite;
        paddr_next   = paddr;
        pwdata_next  = pwdata;

        if (accept) begin
            addr_next = haddr;
        end

        case (state)
            S_IDLE, S_RENABLE, S_WENABLE: begin
                if (accept) begin
                    state_next = hwrite_reg ? S_WWAIT : S_READ;
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_READ:  state_next = S_RENABLE;
            S_WWAIT: state_next = S_WRITE;
            S_WRITE: state_next = S_WENABLE;
            default: state_next = S_IDLE;
        endcase

        case (state_next)
            S_IDLE: begin
                hready_next  = 1'b1;
                psel_next    = 3'b000;
                penable_next = 1'b0;
                pwrite_next  = 1'b0;
            end
            S_READ: begin
                hready_next  = 1'b0;
                psel_next    = decode(haddr[31:26]);
                paddr_next   = haddr;
                penable_next = 1'b0;
                pwrite_next  = 1'b0;
            end
            S_RENABLE: begin
                hready_next  = 1'b1;
                penable_next = 1'b1;
            end
            S_WWAIT: begin
                hready_next  = 1'b0;
                psel_next    = 3'b000;
                penable_next = 1'b0;
                pwrite_next  = 1'b0;
            end
            S_WRITE: begin
                hready_next  = 1'b0;
                psel_next    = decode(addr_reg[31:26]);
                paddr_next   = addr_reg;
                pwdata_next  = hwdata;
                penable_next = 1'b0;
                pwrite_next  = 1'b1;
            end
            S_WENABLE: begin
                hready_next  = 1'b1;
                penable_next = 1'b1;
            end
            default: begin
                hready_next  = 1'b1;
                psel_next    = 3'b000;
                penable_next = 1'b0;
                pwrite_next  = 1'b0;
            end
        endcase
    end

    // State, latched address and APB/AHB output registers.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state      <= S_IDLE;
            addr_reg   <= 32'h0;
            hready_out <= 1'b1;
            psel       <= 3'b000;
            penable    <= 1'b0;
            pwrite     <= 1'b0;
            paddr      <= 32'h0;
            pwdata     <= 32'h0;
        end else begin
            state      <= state_next;
            addr_reg   <= addr_next;
            hready_out <= hready_next;
            psel       <= psel_next;
            penable    <= penable_next;
            pwrite     <= pwrite_next;
            paddr      <= paddr_next;
            pwdata     <= pwdata_next;
        end
    end

    // Read data return: capture at the end of a read ACCESS, strobe once.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            hrdata  <= 32'h0;
            rd_done <= 1'b0;
        end else begin
            rd_done <= (state == S_RENABLE);
            if (state == S_RENABLE) begin
                hrdata <= prdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_fsm.sv
// tb_apb_master_fsm
// Directed bench for apb_master_fsm. Inputs change and outputs are sampled
// 1 ns after each rising edge, so each sample shows the cycle that edge began.

module tb_apb_master_fsm;

    logic        Hclk;
    logic        Hresetn;
    logic        valid;
    logic        hwrite_reg;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic [31:0] prdata;
    logic        hready_out;
    logic [31:0] hrdata;
    logic        rd_done;
    logic        pwrite;
    logic        penable;
    logic [2:0]  psel;
    logic [31:0] paddr;
    logic [31:0] pwdata;

    int checks   = 0;
    int failures = 0;

    apb_master_fsm dut (
        .Hclk       (Hclk),
        .Hresetn    (Hresetn),
        .valid      (valid),
        .hwrite_reg (hwrite_reg),
        .haddr      (haddr),
        .hwdata     (hwdata),
        .prdata     (prdata),
        .hready_out (hready_out),
        .hrdata     (hrdata),
        .rd_done    (rd_done),
        .pwrite     (pwrite),
        .penable    (penable),
        .psel       (psel),
        .paddr      (paddr),
        .pwdata     (pwdata)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    task automatic tick();
        @(posedge Hclk);
        #1;
    endtask

    task automatic test_reset();
        Hresetn = 1'b1;
        valid = 1'b0; hwrite_reg = 1'b0; haddr = 32'h0; hwdata = 32'h0; prdata = 32'h0;
        #2 Hresetn = 1'b0;
        tick();
        tick();
        checks++;
        if (hready_out !== 1'b1 || psel !== 3'b000 || penable !== 1'b0 || pwrite !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ctrl: hready=%b psel=%b penable=%b pwrite=%b, required 1 000 0 0", hready_out, psel, penable, pwrite);
        end
        checks++;
        if (paddr !== 32'h0 || pwdata !== 32'h0 || hrdata !== 32'h0 || rd_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_data: paddr=%h pwdata=%h hrdata=%h rd_done=%b, required zeros", paddr, pwdata, hrdata, rd_done);
        end
        Hresetn = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        valid = 1'b1; hwrite_reg = 1'b1; haddr = 32'h8000_0010;
        tick();
        valid = 1'b0; haddr = 32'h0; hwdata = 32'hA5A5_0001;
        checks++;
        if (hready_out !== 1'b0 || psel !== 3'b000 || penable !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wr_wwait: hready=%b psel=%b penable=%b, required 0 000 0", hready_out, psel, penable);
        end
        tick();
        hwdata = 32'hDEAD_BEEF;
        checks++;
        if (psel !== 3'b001 || paddr !== 32'h8000_0010 || pwdata !== 32'hA5A5_0001 || pwrite !== 1'b1 || penable !== 1'b0 || hready_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL wr_setup: psel=%b paddr=%h pwdata=%h pwrite=%b penable=%b hready=%b, required 001 80000010 a5a50001 1 0 0", psel, paddr, pwdata, pwrite, penable, hready_out);
        end
        tick();
        checks++;
        if (penable !== 1'b1 || psel !== 3'b001 || pwdata !== 32'hA5A5_0001 || pwrite !== 1'b1 || hready_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL wr_access: penable=%b psel=%b pwdata=%h pwrite=%b hready=%b, required 1 001 a5a50001 1 1", penable, psel, pwdata, pwrite, hready_out);
        end
        tick();
        checks++;
        if (psel !== 3'b000 || penable !== 1'b0 || hready_out !== 1'b1 || rd_done !== 1'b0 || hrdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL wr_idle: psel=%b penable=%b hready=%b rd_done=%b hrdata=%h, required 000 0 1 0 00000000", psel, penable, hready_out, rd_done, hrdata);
        end
    endtask

    task automatic test_single_read();
        valid = 1'b1; hwrite_reg = 1'b0; haddr = 32'h8400_0020;
        tick();
        valid = 1'b0; haddr = 32'h0; prdata = 32'h0000_005C;
        checks++;
        if (psel !== 3'b010 || paddr !== 32'h8400_0020 || pwrite !== 1'b0 || penable !== 1'b0 || hready_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rd_setup: psel=%b paddr=%h pwrite=%b penable=%b hready=%b, required 010 84000020 0 0 0", psel, paddr, pwrite, penable, hready_out);
        end
        tick();
        checks++;
        if (psel !== 3'b010 || penable !== 1'b1 || hready_out !== 1'b1 || rd_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rd_access: psel=%b penable=%b hready=%b rd_done=%b, required 010 1 1 0", psel, penable, hready_out, rd_done);
        end
        tick();
        prdata = 32'h1111_1111;
        checks++;
        if (hrdata !== 32'h0000_005C || rd_done !== 1'b1 || psel !== 3'b000 || penable !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rd_done: hrdata=%h rd_done=%b psel=%b penable=%b, required 0000005c 1 000 0", hrdata, rd_done, psel, penable);
        end
        tick();
        checks++;
        if (hrdata !== 32'h0000_005C || rd_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rd_hold: hrdata=%h rd_done=%b, required 0000005c 0", hrdata, rd_done);
        end
    endtask

    task automatic test_back_to_back();
        valid = 1'b1; hwrite_reg = 1'b1; haddr = 32'h8800_0000;
        tick();
        valid = 1'b0; haddr = 32'h0; hwdata = 32'h1234_5678;
        checks++;
        if (penable !== 1'b0 || psel !== 3'b000) begin
            failures++;
            $display("[TB] FAIL b2b_wwait: penable=%b psel=%b, required 0 000", penable, psel);
        end
        tick();
        checks++;
        if (penable !== 1'b0 || psel !== 3'b100 || pwdata !== 32'h1234_5678 || paddr !== 32'h8800_0000) begin
            failures++;
            $display("[TB] FAIL b2b_wsetup: penable=%b psel=%b pwdata=%h paddr=%h, required 0 100 12345678 88000000", penable, psel, pwdata, paddr);
        end
        tick();
        checks++;
        if (penable !== 1'b1 || psel !== 3'b100 || hready_out !== 1'b1) begin
            failures++;
            $display("[TB] FAIL b2b_waccess: penable=%b psel=%b hready=%b, required 1 100 1", penable, psel, hready_out);
        end
        valid = 1'b1; hwrite_reg = 1'b0; haddr = 32'h8800_0004;
        tick();
        valid = 1'b0; haddr = 32'h0; prdata = 32'hCAFE_0001;
        checks++;
        if (penable !== 1'b0 || psel !== 3'b100 || paddr !== 32'h8800_0004 || pwrite !== 1'b0 || hready_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL b2b_rsetup: penable=%b psel=%b paddr=%h pwrite=%b hready=%b, required 0 100 88000004 0 0", penable, psel, paddr, pwrite, hready_out);
        end
        tick();
        checks++;
        if (penable !== 1'b1 || psel !== 3'b100) begin
            failures++;
            $display("[TB] FAIL b2b_raccess: penable=%b psel=%b, required 1 100", penable, psel);
        end
        tick();
        checks++;
        if (hrdata !== 32'hCAFE_0001 || rd_done !== 1'b1 || psel !== 3'b000) begin
            failures++;
            $display("[TB] FAIL b2b_rdone: hrdata=%h rd_done=%b psel=%b, required cafe0001 1 000", hrdata, rd_done, psel);
        end
    endtask

    task automatic test_out_of_map();
        valid = 1'b1; hwrite_reg = 1'b0; haddr = 32'h9000_0000;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (hready_out !== 1'b1 || psel !== 3'b000 || penable !== 1'b0 || rd_done !== 1'b0) begin
                failures++;
                $display("[TB] FAIL oom_%0d: hready=%b psel=%b penable=%b rd_done=%b, required 1 000 0 0", i, hready_out, psel, penable, rd_done);
            end
        end
        haddr = 32'h8C00_0000;
        tick();
        checks++;
        if (hready_out !== 1'b1 || psel !== 3'b000) begin
            failures++;
            $display("[TB] FAIL oom_edge: hready=%b psel=%b, required 1 000", hready_out, psel);
        end
        haddr = 32'h83FF_FFFC;
        tick();
        valid = 1'b0; haddr = 32'h0;
        checks++;
        if (psel !== 3'b001 || paddr !== 32'h83FF_FFFC || hready_out !== 1'b0) begin
            failures++;
            $display("[TB] FAIL map_top0: psel=%b paddr=%h hready=%b, required 001 83fffffc 0", psel, paddr, hready_out);
        end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_write();
        valid = 1'b1; hwrite_reg = 1'b1; haddr = 32'h8000_0040;
        tick();
        valid = 1'b0; haddr = 32'h0; hwdata = 32'h7777_0007;
        tick();
        checks++;
        if (psel !== 3'b001 || pwrite !== 1'b1 || penable !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_pre: psel=%b pwrite=%b penable=%b, required 001 1 0", psel, pwrite, penable);
        end
        #3 Hresetn = 1'b0;
        #1;
        checks++;
        if (psel !== 3'b000 || pwrite !== 1'b0 || penable !== 1'b0 || hready_out !== 1'b1 || paddr !== 32'h0 || pwdata !== 32'h0 || hrdata !== 32'h0 || rd_done !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_async: psel=%b pwrite=%b penable=%b hready=%b paddr=%h pwdata=%h hrdata=%h rd_done=%b, required reset values", psel, pwrite, penable, hready_out, paddr, pwdata, hrdata, rd_done);
        end
        tick();
        checks++;
        if (penable !== 1'b0 || psel !== 3'b000) begin
            failures++;
            $display("[TB] FAIL rst_noaccess: penable=%b psel=%b, required 0 000", penable, psel);
        end
        Hresetn = 1'b1;
        valid = 1'b1; hwrite_reg = 1'b0; haddr = 32'h8800_0008;
        tick();
        valid = 1'b0; haddr = 32'h0; prdata = 32'h0BAD_F00D;
        checks++;
        if (psel !== 3'b100 || paddr !== 32'h8800_0008 || penable !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_after: psel=%b paddr=%h penable=%b, required 100 88000008 0", psel, paddr, penable);
        end
        tick();
        tick();
        checks++;
        if (hrdata !== 32'h0BAD_F00D || rd_done !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_after_rd: hrdata=%h rd_done=%b, required 0badf00d 1", hrdata, rd_done);
        end
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_back_to_back();
        test_out_of_map();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
